// File: rtl/outer_out_receiver_if.sv
// outer_out_receiver_if: command, core-data and host-data channels of the outer stream receiver.
// slave is the receiver's view; master is the view of whoever drives cmd/core data and consumes d.
interface outer_out_receiver_if #(parameter int CMD_W = 15, parameter int DATA_W = 64);
    logic [CMD_W-1:0]  cmd;
    logic              cmd_isReady;
    logic              cmd_canReceive;
    logic              stop;
    logic [DATA_W-1:0] o__out;
    logic              o__out_isReady;
    logic              o__out_canReceive;
    logic [DATA_W-1:0] d;
    logic              d_isReady;
    logic              d_canReceive;
    logic              d_isLast;
    logic              busy;
    logic              err;
    modport slave (
        input  cmd, cmd_isReady, stop, o__out, o__out_isReady, d_canReceive,
        output cmd_canReceive, o__out_canReceive, d, d_isReady, d_isLast, busy, err
    );
    modport master (
        output cmd, cmd_isReady, stop, o__out, o__out_isReady, d_canReceive,
        input  cmd_canReceive, o__out_canReceive, d, d_isReady, d_isLast, busy, err
    );
endinterface

// File: rtl/outer_out_receiver.sv
// outer_out_receiver: buffers the core's outer stream and restores isLast from a commanded length or stop.
// Optional OUTER_RX_ERR_EN builds sticky protocol-error detection on err.
module outer_out_receiver #(
    parameter int DEPTH            = 4,
    parameter int Outer_MaxWordLen = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    outer_out_receiver_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [Outer_MaxWordLen-1:0] ONE = 1;
    typedef enum logic [1:0] {IDLE, COUNT, OPEN} state_t;
    state_t                      state_q, state_d;
    logic [Outer_MaxWordLen-1:0] cnt_q, cnt_d;
    logic                        pend_q, pend_d;
    logic [AW:0]                 wr_q, rd_q;
    logic [64:0]                 mem_q [DEPTH];
    logic                        full, empty, wr_en, rd_en, last_w;
    logic [64:0]                 head;
    assign empty  = wr_q == rd_q;
    assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head   = mem_q[rd_q[AW-1:0]];
    assign wr_en  = bus.o__out_isReady & bus.o__out_canReceive;
    assign rd_en  = bus.d_isReady & bus.d_canReceive;
    // a pending stop from an earlier cycle tags the next accepted word just like a coincident one
    assign last_w = state_q == COUNT ? cnt_q == ONE : (bus.stop | pend_q);
    assign bus.cmd_canReceive    = state_q == IDLE;
    assign bus.o__out_canReceive = state_q != IDLE && !full;
    assign bus.busy              = state_q != IDLE;
    assign bus.d_isReady         = !empty;
    assign bus.d                 = empty ? '0 : head[63:0];
    assign bus.d_isLast          = !empty & head[64];
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: if (bus.cmd_isReady) begin
                state_d = bus.cmd != '0 ? COUNT : OPEN;
                cnt_d   = bus.cmd;
                pend_d  = 1'b0;
            end
            COUNT: if (wr_en) begin
                cnt_d   = cnt_q - ONE;
                state_d = last_w ? IDLE : COUNT;
            end
            OPEN: if (wr_en && last_w) begin
                state_d = IDLE;
                pend_d  = 1'b0;
            end else if (bus.stop) begin
                pend_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            wr_q    <= wr_q + (AW+1)'(wr_en);
            rd_q    <= rd_q + (AW+1)'(rd_en);
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= {last_w, bus.o__out};
    end
`ifdef OUTER_RX_ERR_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else if ((state_q == IDLE && bus.o__out_isReady) || (bus.cmd_isReady && !bus.cmd_canReceive)) err_q <= 1'b1;
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_outer_out_receiver.sv
// tb_outer_out_receiver: randomized scoreboard bench; the driver pushes each accepted word with its
// model-derived last flag, and an independent monitor pops and compares on every host handshake.
module tb_outer_out_receiver;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    outer_out_receiver_if bus();
    outer_out_receiver dut (.clk(clk), .rst(rst), .bus(bus));
`ifdef OUTER_RX_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif
    typedef struct {logic [63:0] data; logic last; int cyc;} exp_t;
    exp_t sb[$];
    int checks = 0, fails = 0, cyc = 0, acc_cnt = 0;
    bit strict = 0, rand_host = 0, gaps = 0;
    logic host_rdy = 1'b1, rnd_rdy = 1'b1;
    assign bus.d_canReceive = rand_host ? rnd_rdy : host_rdy;
    always @(posedge clk) begin
        cyc++;
        #1 rnd_rdy = ($urandom % 4) != 0;
    end
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (rst && bus.d_isReady && bus.d_canReceive) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_output: got %0h expected none", bus.d);
            end else begin
                e = sb.pop_front();
                chk("d", bus.d, e.data);
                chk("d_isLast", bus.d_isLast, e.last);
                if (strict) chk("latency", cyc - e.cyc, 1);
                else chk("not_early", cyc > e.cyc, 1);
            end
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic timeout(input string name);
        checks++;
        fails++;
        $display("FAIL timeout_%s: got no handshake expected one within bound", name);
    endtask
    task automatic issue_cmd(input int len);
        int n = 0;
        bus.cmd = 15'(len);
        bus.cmd_isReady = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.cmd_canReceive) break;
            if (++n > 200) begin timeout("cmd"); break; end
            step();
        end
        step();
        bus.cmd_isReady = 1'b0;
    endtask
    // last word index comes from the transfer rule: the length, or the word that meets (or follows) stop
    task automatic send_words(input int len, input int nwords, input int stop_at, input bit pre_stop);
        int lastix;
        logic [63:0] w;
        lastix = len != 0 ? len : (pre_stop ? 1 : stop_at);
        if (pre_stop) begin
            bus.stop = 1'b1;
            step();
            step();
            bus.stop = 1'b0;
        end
        for (int i = 1; i <= nwords; i++) begin
            int n = 0;
            w = {$urandom, $urandom};
            forever begin
                bus.o__out = w;
                bus.o__out_isReady = gaps ? ($urandom % 3 != 0) : 1'b1;
                bus.stop = len == 0 && i == stop_at;
                @(negedge clk);
                if (bus.o__out_isReady && bus.o__out_canReceive) begin
                    sb.push_back('{w, i == lastix, cyc});
                    acc_cnt++;
                    step();
                    break;
                end
                if (++n > 500) begin timeout("data"); break; end
                step();
            end
        end
        bus.o__out_isReady = 1'b0;
        bus.stop = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while (sb.size() != 0) begin
            step();
            if (++n > 500) begin timeout("drain"); sb.delete(); break; end
        end
        step();
    endtask
    initial begin
        int a0;
        bus.cmd = '0; bus.cmd_isReady = 0; bus.stop = 0; bus.o__out = '0; bus.o__out_isReady = 0;
        #12;
        chk("rst_cmd_canReceive", bus.cmd_canReceive, 1);
        chk("rst_o_canReceive", bus.o__out_canReceive, 0);
        chk("rst_d_isReady", bus.d_isReady, 0);
        chk("rst_d_isLast", bus.d_isLast, 0);
        chk("rst_d", bus.d, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        step();
        rst = 1'b1;
        step();
        // counted, back-to-back, host always ready: exact one-cycle latency
        strict = 1;
        issue_cmd(3);
        chk("busy_count", bus.busy, 1);
        send_words(3, 3, 0, 0);
        @(negedge clk);
        chk("busy_after_last", bus.busy, 0);
        step();
        drain();
        strict = 0;
        // backpressure against a 4-deep FIFO
        host_rdy = 0;
        a0 = acc_cnt;
        issue_cmd(6);
        fork
            send_words(6, 6, 0, 0);
            begin
                repeat (12) step();
                chk("bp_accepted", acc_cnt - a0, 4);
                chk("bp_canReceive", bus.o__out_canReceive, 0);
                host_rdy = 1;
                step();
                host_rdy = 0;
                repeat (6) step();
                chk("bp_one_more", acc_cnt - a0, 5);
                host_rdy = 1;
            end
        join
        drain();
        // open-ended: coincident stop, then pending stop
        issue_cmd(0);
        chk("busy_open", bus.busy, 1);
        send_words(0, 5, 5, 0);
        drain();
        issue_cmd(0);
        send_words(0, 1, 0, 1);
        drain();
        chk("busy_idle_open", bus.busy, 0);
        // back-to-back commands while FIFO still holds the first transfer
        host_rdy = 0;
        issue_cmd(2);
        send_words(2, 2, 0, 0);
        issue_cmd(1);
        send_words(1, 1, 0, 0);
        chk("b2b_pending", bus.d_isReady, 1);
        host_rdy = 1;
        drain();
        // unsolicited data in IDLE
        bus.o__out = 64'hDEAD;
        bus.o__out_isReady = 1'b1;
        @(negedge clk);
        chk("unsolicited_blocked", bus.o__out_canReceive, 0);
        step();
        bus.o__out_isReady = 1'b0;
        @(negedge clk);
        chk("err_set", bus.err, ERR_EXP);
        step();
        issue_cmd(2);
        send_words(2, 2, 0, 0);
        drain();
        chk("err_sticky", bus.err, ERR_EXP);
        // reset mid-transfer
        host_rdy = 0;
        issue_cmd(4);
        send_words(4, 2, 0, 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_d_isReady", bus.d_isReady, 0);
        chk("mid_rst_cmd_canReceive", bus.cmd_canReceive, 1);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_err", bus.err, 0);
        sb.delete();
        step();
        rst = 1'b1;
        host_rdy = 1;
        issue_cmd(1);
        send_words(1, 1, 0, 0);
        drain();
        chk("post_rst_busy", bus.busy, 0);
        // randomized traffic with gaps and host stalls
        rand_host = 1;
        gaps = 1;
        repeat (40) begin
            int len, k;
            bit ps;
            len = $urandom_range(0, 6);
            if (len != 0) begin
                issue_cmd(len);
                send_words(len, len, 0, 0);
            end else begin
                ps = $urandom_range(0, 1);
                k = $urandom_range(1, 5);
                issue_cmd(0);
                send_words(0, ps ? 1 : k, ps ? 0 : k, ps);
            end
        end
        drain();
        chk("final_busy", bus.busy, 0);
        chk("final_d_isReady", bus.d_isReady, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish within 2ms");
        $fatal(1, "watchdog expired");
    end
endmodule
